// File: rtl/ctrl_wb_initiator_pkg.sv
// Shared types and default widths for the Wishbone B4 single-transfer initiator.
package ctrl_wb_initiator_pkg;

  localparam int unsigned ADDR_WIDTH    = 4;
  localparam int unsigned DATA_WIDTH    = 8;
  localparam int unsigned TIMEOUT_TICKS = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/ctrl_wb_initiator_if.sv
// Request/response port plus Wishbone bus of the initiator; master = initiator side,
// slave = command source and responder side.
interface ctrl_wb_initiator_if
  import ctrl_wb_initiator_pkg::*;
#(
  parameter int unsigned AddrWidth = ADDR_WIDTH,
  parameter int unsigned DataWidth = DATA_WIDTH
);

  logic                 req_valid_i;
  logic                 req_ready_o;
  logic                 req_we_i;
  logic [AddrWidth-1:0] req_adr_i;
  logic [DataWidth-1:0] req_dat_i;
  logic                 rsp_valid_o;
  logic [DataWidth-1:0] rsp_dat_o;
  logic                 rsp_err_o;
  logic                 wb_cyc_o;
  logic                 wb_stb_o;
  logic                 wb_we_o;
  logic [AddrWidth-1:0] wb_adr_o;
  logic [DataWidth-1:0] wb_dat_o;
  logic [DataWidth-1:0] wb_dat_i;
  logic                 wb_ack_i;

  modport master (
    input  req_valid_i, req_we_i, req_adr_i, req_dat_i, wb_dat_i, wb_ack_i,
    output req_ready_o, rsp_valid_o, rsp_dat_o, rsp_err_o,
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o
  );

  modport slave (
    output req_valid_i, req_we_i, req_adr_i, req_dat_i, wb_dat_i, wb_ack_i,
    input  req_ready_o, rsp_valid_o, rsp_dat_o, rsp_err_o,
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o
  );

endinterface

// File: rtl/ctrl_wb_initiator.sv
// Wishbone B4 initiator: one classic single cycle per accepted command, one-cycle response pulse.
// Optional ack timeout abort is enabled by defining WB_TIMEOUT_EN.
module ctrl_wb_initiator
  import ctrl_wb_initiator_pkg::*;
#(
  parameter int unsigned AddrWidth    = ADDR_WIDTH,
  parameter int unsigned DataWidth    = DATA_WIDTH,
  parameter int unsigned TimeoutTicks = TIMEOUT_TICKS
) (
  input logic               clk_i,
  input logic               rst_i,
  ctrl_wb_initiator_if.master bus
);

  state_t               state;
  state_t               state_next;
  logic                 accept;
  logic                 timeout_hit;

  logic                 wb_cyc;
  logic                 wb_we;
  logic [AddrWidth-1:0] wb_adr;
  logic [DataWidth-1:0] wb_dat;
  logic                 rsp_valid;
  logic [DataWidth-1:0] rsp_dat;
  logic                 rsp_err;

  logic                 wb_cyc_next;
  logic                 wb_we_next;
  logic [AddrWidth-1:0] wb_adr_next;
  logic [DataWidth-1:0] wb_dat_next;
  logic                 rsp_valid_next;
  logic [DataWidth-1:0] rsp_dat_next;
  logic                 rsp_err_next;

  assign accept          = bus.req_valid_i && (state == ST_IDLE);
  assign bus.req_ready_o = (state == ST_IDLE);

`ifdef WB_TIMEOUT_EN
  localparam int unsigned TimeoutCntWidth = $clog2(TimeoutTicks);

  logic [TimeoutCntWidth-1:0] timeout_cnt;

  // Counts BUS cycles without ack; restarts with every accepted command.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      timeout_cnt <= {TimeoutCntWidth{1'b0}};
    end else if (accept) begin
      timeout_cnt <= {TimeoutCntWidth{1'b0}};
    end else if ((state == ST_BUS) && !bus.wb_ack_i) begin
      timeout_cnt <= timeout_cnt + TimeoutCntWidth'(1);
    end else begin
      timeout_cnt <= timeout_cnt;
    end
  end

  // An ack on the final allowed cycle still completes normally.
  assign timeout_hit = (state == ST_BUS) && !bus.wb_ack_i &&
                       (timeout_cnt == TimeoutCntWidth'(TimeoutTicks - 1));
`else
  assign timeout_hit = 1'b0 && (TimeoutTicks < 2);
`endif

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_next = ST_BUS;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_BUS: begin
        if (bus.wb_ack_i || timeout_hit) begin
          state_next = ST_RESP;
        end else begin
          state_next = ST_BUS;
        end
      end
      ST_RESP: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs; anything not touched holds.
  always_comb begin
    wb_cyc_next    = wb_cyc;
    wb_we_next     = wb_we;
    wb_adr_next    = wb_adr;
    wb_dat_next    = wb_dat;
    rsp_valid_next = 1'b0;
    rsp_dat_next   = rsp_dat;
    rsp_err_next   = rsp_err;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          wb_cyc_next = 1'b1;
          wb_we_next  = bus.req_we_i;
          wb_adr_next = bus.req_adr_i;
          wb_dat_next = bus.req_dat_i;
        end else begin
          wb_cyc_next = 1'b0;
        end
      end
      ST_BUS: begin
        if (bus.wb_ack_i) begin
          wb_cyc_next    = 1'b0;
          rsp_valid_next = 1'b1;
          rsp_dat_next   = wb_we ? {DataWidth{1'b0}} : bus.wb_dat_i;
          rsp_err_next   = 1'b0;
        end else if (timeout_hit) begin
          wb_cyc_next    = 1'b0;
          rsp_valid_next = 1'b1;
          rsp_dat_next   = {DataWidth{1'b0}};
          rsp_err_next   = 1'b1;
        end else begin
          wb_cyc_next = 1'b1;
        end
      end
      ST_RESP: begin
        wb_cyc_next    = 1'b0;
        rsp_valid_next = 1'b0;
      end
      default: begin
        wb_cyc_next    = 1'b0;
        rsp_valid_next = 1'b0;
      end
    endcase
  end

  // Output registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wb_cyc    <= 1'b0;
      wb_we     <= 1'b0;
      wb_adr    <= {AddrWidth{1'b0}};
      wb_dat    <= {DataWidth{1'b0}};
      rsp_valid <= 1'b0;
      rsp_dat   <= {DataWidth{1'b0}};
      rsp_err   <= 1'b0;
    end else begin
      wb_cyc    <= wb_cyc_next;
      wb_we     <= wb_we_next;
      wb_adr    <= wb_adr_next;
      wb_dat    <= wb_dat_next;
      rsp_valid <= rsp_valid_next;
      rsp_dat   <= rsp_dat_next;
      rsp_err   <= rsp_err_next;
    end
  end

  // Single transfers only, so strobe simply mirrors cycle.
  assign bus.wb_cyc_o    = wb_cyc;
  assign bus.wb_stb_o    = wb_cyc;
  assign bus.wb_we_o     = wb_we;
  assign bus.wb_adr_o    = wb_adr;
  assign bus.wb_dat_o    = wb_dat;
  assign bus.rsp_valid_o = rsp_valid;
  assign bus.rsp_dat_o   = rsp_dat;
  assign bus.rsp_err_o   = rsp_err;

endmodule

// File: tb/tb_ctrl_wb_initiator.sv
// Scoreboard bench for ctrl_wb_initiator with a behavioural Wishbone responder.
// Covers the WB_TIMEOUT_EN build as well as the default one.
module tb_ctrl_wb_initiator;
  import ctrl_wb_initiator_pkg::*;

  localparam int TICKS = 16;
`ifdef WB_TIMEOUT_EN
  localparam int HOLD = 3;
`else
  localparam int HOLD = 110;
`endif

  typedef struct packed {
    logic [7:0] dat;
    logic       err;
  } rsp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ctrl_wb_initiator_if #(.AddrWidth(4), .DataWidth(8)) bus ();

  ctrl_wb_initiator #(.AddrWidth(4), .DataWidth(8), .TimeoutTicks(TICKS)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  int   checks = 0;
  int   failures = 0;
  rsp_t exp_q[$];
  logic [7:0] mem [16];
  logic [7:0] model_mem [16];
  logic       resp_en = 1'b1;
  logic       spur_ack = 1'b0;
  int   wait_states = 0;
  int   stb_cnt = 0;
  int   ncyc = 0;
  int   stb_hi = 0;
  int   rsp_cnt = 0;
  int   ready_lo = 0;
  logic       exp_we = 1'b0;
  logic [3:0] exp_adr = 4'd0;
  logic [7:0] exp_dat = 8'd0;

  // Responder: acks after wait_states stall cycles, plus an optional stray ack.
  assign bus.wb_ack_i = spur_ack | (bus.wb_stb_o & resp_en & (stb_cnt == wait_states));
  assign bus.wb_dat_i = mem[bus.wb_adr_o];

  always @(posedge clk) begin
    if (bus.wb_stb_o && !bus.wb_ack_i) stb_cnt <= stb_cnt + 1;
    else stb_cnt <= 0;
    if (bus.wb_stb_o && bus.wb_ack_i && bus.wb_we_o) mem[bus.wb_adr_o] <= bus.wb_dat_o;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at ncyc=%0d", ncyc);
    $fatal(1);
  end

  // Advance to the next falling edge and observe the bus and response port there.
  task automatic tick();
    rsp_t e;
    @(negedge clk);
    ncyc++;
    if (bus.wb_stb_o === 1'b1) begin
      stb_hi++;
      checks++;
      if ({bus.wb_cyc_o, bus.wb_we_o, bus.wb_adr_o, bus.wb_dat_o} !== {1'b1, exp_we, exp_adr, exp_dat}) begin
        failures++;
        $display("FAIL bus_fields got cyc=%b we=%b adr=%h dat=%h want cyc=1 we=%b adr=%h dat=%h",
                 bus.wb_cyc_o, bus.wb_we_o, bus.wb_adr_o, bus.wb_dat_o, exp_we, exp_adr, exp_dat);
      end
    end
    if (bus.req_ready_o === 1'b0) ready_lo++;
    if (bus.rsp_valid_o === 1'b1) begin
      rsp_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL rsp_unexpected got dat=%h err=%b want no response", bus.rsp_dat_o, bus.rsp_err_o);
      end else begin
        e = exp_q.pop_front();
        if ({bus.rsp_dat_o, bus.rsp_err_o} !== {e.dat, e.err}) begin
          failures++;
          $display("FAIL rsp_payload got dat=%h err=%b want dat=%h err=%b",
                   bus.rsp_dat_o, bus.rsp_err_o, e.dat, e.err);
        end
      end
    end
  endtask

  task automatic send(input logic we, input logic [3:0] adr, input logic [7:0] dat,
                      input bit want_rsp, input bit want_err, output int acc);
    rsp_t e;
    int   n;
    bus.req_valid_i = 1'b1;
    bus.req_we_i    = we;
    bus.req_adr_i   = adr;
    bus.req_dat_i   = dat;
    n = 0;
    while (bus.req_ready_o !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout got ready=%b want 1", bus.req_ready_o);
    end
    acc     = ncyc;
    exp_we  = we;
    exp_adr = adr;
    exp_dat = dat;
    if (we) model_mem[adr] = dat;
    if (want_rsp) begin
      e.err = want_err;
      e.dat = (we || want_err) ? 8'h00 : model_mem[adr];
      exp_q.push_back(e);
    end
    tick();
    bus.req_valid_i = 1'b0;
  endtask

  task automatic wait_rsp(input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (bus.rsp_valid_o === 1'b1) begin
        at = ncyc;
        break;
      end
    end
    if (at < 0) begin
      checks++;
      failures++;
      $display("FAIL rsp_timeout got no rsp_valid within %0d cycles", budget);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req_valid_i = 1'b0;
    bus.req_we_i    = 1'b0;
    bus.req_adr_i   = 4'd0;
    bus.req_dat_i   = 8'd0;
    for (int i = 0; i < 16; i++) begin
      mem[i]       = 8'hEE;
      model_mem[i] = 8'hEE;
    end
    repeat (3) tick();
    checks++;
    if ({bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o, bus.wb_adr_o, bus.wb_dat_o} !== 15'd0) begin
      failures++;
      $display("FAIL reset_bus got cyc=%b stb=%b we=%b adr=%h dat=%h want all 0",
               bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o, bus.wb_adr_o, bus.wb_dat_o);
    end
    checks++;
    if ({bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_dat_o} !== 10'd0) begin
      failures++;
      $display("FAIL reset_rsp got valid=%b err=%b dat=%h want all 0",
               bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_dat_o);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (bus.req_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready got %b want 1", bus.req_ready_o);
    end
  endtask

  task automatic test_write();
    int a, r;
    stb_hi = 0;
    wait_states = 0;
    send(1'b1, 4'd3, 8'h1F, 1'b1, 1'b0, a);
    checks++;
    if (bus.wb_stb_o !== 1'b1) begin
      failures++;
      $display("FAIL write_stb got %b want 1", bus.wb_stb_o);
    end
    wait_rsp(10, r);
    checks++;
    if (r - a != 2) begin
      failures++;
      $display("FAIL write_latency got %0d want 2", r - a);
    end
    checks++;
    if (stb_hi != 1) begin
      failures++;
      $display("FAIL write_stb_cycles got %0d want 1", stb_hi);
    end
    tick();
    checks++;
    if ({bus.rsp_valid_o, bus.req_ready_o, bus.wb_stb_o} !== 3'b010) begin
      failures++;
      $display("FAIL write_after got valid=%b ready=%b stb=%b want 0 1 0",
               bus.rsp_valid_o, bus.req_ready_o, bus.wb_stb_o);
    end
    checks++;
    if ({bus.wb_we_o, bus.wb_adr_o, bus.wb_dat_o, mem[3]} !== {1'b1, 4'd3, 8'h1F, 8'h1F}) begin
      failures++;
      $display("FAIL write_hold got we=%b adr=%h dat=%h mem=%h want 1 3 1f 1f",
               bus.wb_we_o, bus.wb_adr_o, bus.wb_dat_o, mem[3]);
    end
  endtask

  task automatic test_read_wait();
    int a, r;
    mem[5]       = 8'hA5;
    model_mem[5] = 8'hA5;
    wait_states  = 3;
    stb_hi       = 0;
    ready_lo     = 0;
    send(1'b0, 4'd5, 8'h00, 1'b1, 1'b0, a);
    wait_rsp(20, r);
    checks++;
    if (r - a != 5) begin
      failures++;
      $display("FAIL read_latency got %0d want 5", r - a);
    end
    checks++;
    if (stb_hi != 4) begin
      failures++;
      $display("FAIL read_stb_cycles got %0d want 4", stb_hi);
    end
    checks++;
    if (ready_lo != 5) begin
      failures++;
      $display("FAIL read_ready_low got %0d want 5", ready_lo);
    end
    tick();
    checks++;
    if ({bus.req_ready_o, bus.rsp_valid_o, bus.rsp_dat_o} !== {1'b1, 1'b0, 8'hA5}) begin
      failures++;
      $display("FAIL read_hold got ready=%b valid=%b dat=%h want 1 0 a5",
               bus.req_ready_o, bus.rsp_valid_o, bus.rsp_dat_o);
    end
    wait_states = 0;
  endtask

  task automatic test_back_to_back();
    logic       cw [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [3:0] ca [4] = '{4'd0, 4'd0, 4'd7, 4'd7};
    logic [7:0] cd [4] = '{8'h11, 8'h00, 8'h7E, 8'h00};
    int   acc [4];
    int   k, rsp0;
    rsp_t e;
    k    = 0;
    rsp0 = rsp_cnt;
    bus.req_valid_i = 1'b1;
    bus.req_we_i = cw[0]; bus.req_adr_i = ca[0]; bus.req_dat_i = cd[0];
    for (int n = 0; n < 40 && k < 4; n++) begin
      if (bus.req_ready_o === 1'b1) begin
        acc[k]  = ncyc;
        exp_we  = cw[k];
        exp_adr = ca[k];
        exp_dat = cd[k];
        if (cw[k]) model_mem[ca[k]] = cd[k];
        e.err = 1'b0;
        e.dat = cw[k] ? 8'h00 : model_mem[ca[k]];
        exp_q.push_back(e);
        k++;
        tick();
        if (k < 4) begin
          bus.req_we_i = cw[k]; bus.req_adr_i = ca[k]; bus.req_dat_i = cd[k];
        end else begin
          bus.req_valid_i = 1'b0;
        end
      end else begin
        tick();
      end
    end
    bus.req_valid_i = 1'b0;
    for (int n = 0; n < 10 && rsp_cnt - rsp0 < 4; n++) tick();
    checks++;
    if (k != 4 || rsp_cnt - rsp0 != 4) begin
      failures++;
      $display("FAIL b2b_count got accepted=%0d pulses=%0d want 4 4", k, rsp_cnt - rsp0);
    end
    for (int i = 1; i < 4; i++) begin
      checks++;
      if (k == 4 && acc[i] - acc[i-1] != 3) begin
        failures++;
        $display("FAIL b2b_spacing got %0d want 3 (cmd %0d)", acc[i] - acc[i-1], i);
      end
    end
  endtask

`ifdef WB_TIMEOUT_EN
  task automatic test_timeout();
    int a, r;
    resp_en = 1'b0;
    stb_hi  = 0;
    send(1'b0, 4'd2, 8'h00, 1'b1, 1'b1, a);
    wait_rsp(40, r);
    checks++;
    if (stb_hi != TICKS || r - a != TICKS + 1) begin
      failures++;
      $display("FAIL timeout_abort got stb=%0d lat=%0d want %0d %0d", stb_hi, r - a, TICKS, TICKS + 1);
    end
    tick();
    resp_en      = 1'b1;
    wait_states  = TICKS - 1;
    mem[2]       = 8'h3C;
    model_mem[2] = 8'h3C;
    stb_hi       = 0;
    send(1'b0, 4'd2, 8'h00, 1'b1, 1'b0, a);
    wait_rsp(40, r);
    checks++;
    if (stb_hi != TICKS || bus.rsp_err_o !== 1'b0) begin
      failures++;
      $display("FAIL timeout_ack_wins got stb=%0d err=%b want %0d 0", stb_hi, bus.rsp_err_o, TICKS);
    end
    wait_states = 0;
    tick();
  endtask
`endif

  task automatic test_reset_mid_bus();
    int a, rsp0;
    resp_en = 1'b0;
    stb_hi  = 0;
    rsp0    = rsp_cnt;
    send(1'b0, 4'd9, 8'h00, 1'b0, 1'b0, a);
    repeat (HOLD) tick();
    checks++;
    if (stb_hi != HOLD + 1 || rsp_cnt != rsp0) begin
      failures++;
      $display("FAIL stall_hold got stb=%0d pulses=%0d want %0d 0", stb_hi, rsp_cnt - rsp0, HOLD + 1);
    end
    rst = 1'b1;
    tick();
    checks++;
    if ({bus.wb_cyc_o, bus.wb_stb_o, bus.rsp_valid_o} !== 3'b000) begin
      failures++;
      $display("FAIL midbus_reset got cyc=%b stb=%b valid=%b want 0 0 0",
               bus.wb_cyc_o, bus.wb_stb_o, bus.rsp_valid_o);
    end
    rst     = 1'b0;
    resp_en = 1'b1;
    repeat (3) tick();
    checks++;
    if (bus.req_ready_o !== 1'b1 || rsp_cnt != rsp0) begin
      failures++;
      $display("FAIL midbus_after got ready=%b pulses=%0d want 1 0", bus.req_ready_o, rsp_cnt - rsp0);
    end
  endtask

  task automatic test_spurious_ack();
    int a, r, rsp0;
    rsp0     = rsp_cnt;
    spur_ack = 1'b1;
    repeat (3) tick();
    spur_ack = 1'b0;
    checks++;
    if ({bus.wb_cyc_o, bus.req_ready_o} !== 2'b01 || rsp_cnt != rsp0) begin
      failures++;
      $display("FAIL spur_idle got cyc=%b ready=%b pulses=%0d want 0 1 0",
               bus.wb_cyc_o, bus.req_ready_o, rsp_cnt - rsp0);
    end
    send(1'b1, 4'd1, 8'h42, 1'b1, 1'b0, a);
    wait_rsp(10, r);
    spur_ack = 1'b1;
    repeat (3) tick();
    spur_ack = 1'b0;
    checks++;
    if ({bus.wb_cyc_o, bus.req_ready_o} !== 2'b01 || rsp_cnt - rsp0 != 1) begin
      failures++;
      $display("FAIL spur_resp got cyc=%b ready=%b pulses=%0d want 0 1 1",
               bus.wb_cyc_o, bus.req_ready_o, rsp_cnt - rsp0);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_wait();
    test_back_to_back();
`ifdef WB_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid_bus();
    test_spurious_ack();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got %0d pending want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
